// File: rtl/decouple_fifo_if.sv
// ============================================================================
// Module   : decouple_fifo_if
// Brief    : Producer/consumer valid-ready bundle for decouple_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decouple_fifo_if #(
  parameter int unsigned DIN = 16
);
  logic           din_valid;
  logic [DIN-1:0] din_data;
  logic           din_ready;
  logic           dout_valid;
  logic [DIN-1:0] dout_data;
  logic           dout_ready;

  // master = the environment around the FIFO (producer and consumer)
  modport master (
    output din_valid, din_data, dout_ready,
    input  din_ready, dout_valid, dout_data
  );

  modport slave (
    input  din_valid, din_data, dout_ready,
    output din_ready, dout_valid, dout_data
  );
endinterface

`default_nettype wire

// File: rtl/decouple_fifo.sv
// ============================================================================
// Module   : decouple_fifo
// Brief    : Valid/ready decoupling FIFO, any depth, optional fall-through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decouple_fifo #(
  parameter int unsigned    DIN        = 16,
  parameter int unsigned    DEPTH      = 4,
  parameter logic [DIN-1:0] INIT       = '0,
  parameter bit             INIT_VALID = 1'b0,
  parameter bit             BYPASS     = 1'b0,
  parameter int unsigned    AFULL_TH   = DEPTH - 1,
  parameter int unsigned    AEMPTY_TH  = 1
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         flush,
  decouple_fifo_if.slave                    bus,
  output logic [$clog2(DEPTH+1)-1:0]        level,
  output logic                              almost_full,
  output logic                              almost_empty
);

  localparam int unsigned    LW       = $clog2(DEPTH + 1);
  localparam int unsigned    PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
  localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);

  logic [DIN-1:0] mem_q [DEPTH];
  logic [DIN-1:0] mem_d [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]  level_q, level_d;

  logic           empty, full;
  logic           din_ready, dout_valid;
  logic [DIN-1:0] dout_data;
  logic           push, pop, thru, wr_en, rd_en;

  // Explicit wrap so non-power-of-two depths never index past the last slot
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == FULL_LVL);
    din_ready = ~full & ~flush;
    if (BYPASS && empty) begin
      dout_valid = bus.din_valid & ~flush;
      dout_data  = bus.din_data;
    end else begin
      dout_valid = ~empty & ~flush;
      dout_data  = mem_q[rd_ptr_q];
    end
    push  = bus.din_valid & din_ready;
    pop   = dout_valid & bus.dout_ready;
    // Fall-through word consumed in the same cycle is never stored
    thru  = BYPASS & empty & push & pop;
    wr_en = push & ~thru;
    rd_en = pop & ~empty;
  end

  assign bus.din_ready  = din_ready;
  assign bus.dout_valid = dout_valid;
  assign bus.dout_data  = dout_data;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = bus.din_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= INIT_VALID ? ptr_inc('0) : '0;
      level_q  <= INIT_VALID ? LW'(1) : '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset except the optional preloaded head entry
  always_ff @(posedge clk) begin
    if (rst) begin
      if (INIT_VALID) begin
        mem_q[0] <= INIT;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign level        = level_q;
  assign almost_full  = (32'(level_q) >= AFULL_TH);
  assign almost_empty = (32'(level_q) <= AEMPTY_TH);

endmodule

`default_nettype wire

// File: tb/tb_decouple_fifo.sv
// ============================================================================
// Module   : tb_decouple_fifo
// Brief    : Directed self-checking bench over four decouple_fifo configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decouple_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_a = 1'b0, flush_b = 1'b0, flush_c = 1'b0, flush_d = 1'b0;

  logic [1:0] lvl_a;
  logic [2:0] lvl_b;
  logic [1:0] lvl_c;
  logic [0:0] lvl_d;
  logic af_a, ae_a, af_b, ae_b, af_c, ae_c, af_d, ae_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decouple_fifo_if #(.DIN(8)) if_a ();
  decouple_fifo_if #(.DIN(8)) if_b ();
  decouple_fifo_if #(.DIN(8)) if_c ();
  decouple_fifo_if #(.DIN(8)) if_d ();

  decouple_fifo #(.DIN(8), .DEPTH(3)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a), .bus(if_a),
    .level(lvl_a), .almost_full(af_a), .almost_empty(ae_a));

  decouple_fifo #(.DIN(8), .DEPTH(5)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b), .bus(if_b),
    .level(lvl_b), .almost_full(af_b), .almost_empty(ae_b));

  decouple_fifo #(.DIN(8), .DEPTH(2), .BYPASS(1'b1)) u_c (
    .clk(clk), .rst(rst), .flush(flush_c), .bus(if_c),
    .level(lvl_c), .almost_full(af_c), .almost_empty(ae_c));

  decouple_fifo #(.DIN(8), .DEPTH(1), .INIT(8'h7E), .INIT_VALID(1'b1)) u_d (
    .clk(clk), .rst(rst), .flush(flush_d), .bus(if_d),
    .level(lvl_d), .almost_full(af_d), .almost_empty(ae_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  int         sz;
  bit         dv, dr;
  logic [7:0] dd;
  logic [7:0] exp_a [3];

  initial begin
    if_a.din_valid = 0; if_a.din_data = '0; if_a.dout_ready = 0;
    if_b.din_valid = 0; if_b.din_data = '0; if_b.dout_ready = 0;
    if_c.din_valid = 0; if_c.din_data = '0; if_c.dout_ready = 0;
    if_d.din_valid = 0; if_d.din_data = '0; if_d.dout_ready = 0;
    tick; tick;
    rst = 0;
    #1;

    // Reset state
    chk("a_rst_level",  32'(lvl_a), 0);
    chk("a_rst_dvalid", 32'(if_a.dout_valid), 0);
    chk("a_rst_dready", 32'(if_a.din_ready), 1);
    chk("a_rst_aempty", 32'(ae_a), 1);
    chk("a_rst_afull",  32'(af_a), 0);
    chk("d_rst_level",  32'(lvl_d), 1);
    chk("d_rst_dvalid", 32'(if_d.dout_valid), 1);
    chk("d_rst_data",   32'(if_d.dout_data), 32'h7E);
    chk("d_rst_dready", 32'(if_d.din_ready), 0);

    // Fill DEPTH=3 with consumer stalled, one-cycle latency on first word
    if_a.din_valid = 1; if_a.din_data = 8'hA1;
    tick;
    chk("a_lat_dvalid", 32'(if_a.dout_valid), 1);
    chk("a_lat_data",   32'(if_a.dout_data), 32'hA1);
    if_a.din_data = 8'hA2; tick;
    if_a.din_data = 8'hA3; tick;
    if_a.din_valid = 0; #1;
    chk("a_full_level", 32'(lvl_a), 3);
    chk("a_full_ready", 32'(if_a.din_ready), 0);
    chk("a_full_afull", 32'(af_a), 1);
    chk("a_hold_data",  32'(if_a.dout_data), 32'hA1);

    exp_a[0] = 8'hA1; exp_a[1] = 8'hA2; exp_a[2] = 8'hA3;
    if_a.dout_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("a_drain_valid", 32'(if_a.dout_valid), 1);
      chk("a_drain_data",  32'(if_a.dout_data), 32'(exp_a[i]));
      tick;
    end
    if_a.dout_ready = 0; #1;
    chk("a_empty_level",  32'(lvl_a), 0);
    chk("a_empty_dvalid", 32'(if_a.dout_valid), 0);
    chk("a_empty_aempty", 32'(ae_a), 1);

    // Refill to 3, then flush with both handshakes offered
    if_a.din_valid = 1;
    if_a.din_data = 8'hB1; tick;
    if_a.din_data = 8'hB2; tick;
    if_a.din_data = 8'hB3; tick;
    chk("a_refill_level", 32'(lvl_a), 3);
    flush_a = 1; if_a.dout_ready = 1; #1;
    chk("a_flush_dready", 32'(if_a.din_ready), 0);
    chk("a_flush_dvalid", 32'(if_a.dout_valid), 0);
    tick;
    flush_a = 0; if_a.din_valid = 0; if_a.dout_ready = 0; #1;
    chk("a_postflush_level",  32'(lvl_a), 0);
    chk("a_postflush_dvalid", 32'(if_a.dout_valid), 0);

    // Push after flush, then simultaneous push/pop at level 1
    if_a.din_valid = 1; if_a.din_data = 8'hC1; tick;
    if_a.din_data = 8'hC2; if_a.dout_ready = 1; #1;
    chk("a_pp_head", 32'(if_a.dout_data), 32'hC1);
    tick;
    if_a.din_valid = 0; if_a.dout_ready = 0; #1;
    chk("a_pp_level", 32'(lvl_a), 1);
    chk("a_pp_data",  32'(if_a.dout_data), 32'hC2);

    // Fall-through on empty BYPASS FIFO
    if_c.din_valid = 1; if_c.din_data = 8'h55; if_c.dout_ready = 1; #1;
    chk("c_bp_dvalid", 32'(if_c.dout_valid), 1);
    chk("c_bp_data",   32'(if_c.dout_data), 32'h55);
    tick;
    if_c.din_valid = 0; #1;
    chk("c_bp_level",  32'(lvl_c), 0);
    chk("c_bp_dvalid0", 32'(if_c.dout_valid), 0);

    // Store when consumer stalls, then fill to full
    if_c.dout_ready = 0; if_c.din_valid = 1; if_c.din_data = 8'h66; tick;
    chk("c_store_level", 32'(lvl_c), 1);
    chk("c_store_data",  32'(if_c.dout_data), 32'h66);
    if_c.din_data = 8'h77; tick;
    chk("c_full_level", 32'(lvl_c), 2);
    chk("c_full_ready", 32'(if_c.din_ready), 0);

    // Full: pop happens, push refused, freed slot usable next cycle
    if_c.din_data = 8'h88; if_c.dout_ready = 1; #1;
    chk("c_fullpp_ready", 32'(if_c.din_ready), 0);
    chk("c_fullpp_data",  32'(if_c.dout_data), 32'h66);
    tick;
    chk("c_fullpp_level", 32'(lvl_c), 1);
    chk("c_fullpp_head",  32'(if_c.dout_data), 32'h77);
    chk("c_fullpp_ready1", 32'(if_c.din_ready), 1);
    if_c.dout_ready = 0; tick;
    chk("c_next_level", 32'(lvl_c), 2);
    if_c.din_valid = 0; if_c.dout_ready = 1; #1;
    chk("c_drain0", 32'(if_c.dout_data), 32'h77);
    tick;
    chk("c_drain1", 32'(if_c.dout_data), 32'h88);
    tick;
    if_c.dout_ready = 0; #1;
    chk("c_drain_level", 32'(lvl_c), 0);

    // DEPTH=1 preloaded entry: pop, refill, flush does not reload INIT
    if_d.dout_ready = 1; tick;
    if_d.dout_ready = 0; #1;
    chk("d_pop_ready", 32'(if_d.din_ready), 1);
    chk("d_pop_level", 32'(lvl_d), 0);
    chk("d_pop_dvalid", 32'(if_d.dout_valid), 0);
    if_d.din_valid = 1; if_d.din_data = 8'h33; tick;
    if_d.din_valid = 0; #1;
    chk("d_push_data",  32'(if_d.dout_data), 32'h33);
    chk("d_push_ready", 32'(if_d.din_ready), 0);
    flush_d = 1; tick;
    flush_d = 0; #1;
    chk("d_flush_level",  32'(lvl_d), 0);
    chk("d_flush_dvalid", 32'(if_d.dout_valid), 0);

    // DEPTH=5 concurrent traffic against a queue model
    for (int i = 0; i < 48; i++) begin
      if (i < 20) begin
        dv = ($urandom_range(0, 3) != 0); dr = ($urandom_range(0, 3) == 0);
      end else if (i < 40) begin
        dv = ($urandom_range(0, 3) == 0); dr = ($urandom_range(0, 3) != 0);
      end else begin
        dv = 0; dr = 1;
      end
      dd = 8'($urandom);
      if_b.din_valid = dv; if_b.din_data = dd; if_b.dout_ready = dr;
      #1;
      sz = q.size();
      chk("b_level",  32'(lvl_b), 32'(sz));
      chk("b_ready",  32'(if_b.din_ready), 32'(sz < 5));
      chk("b_dvalid", 32'(if_b.dout_valid), 32'(sz != 0));
      chk("b_afull",  32'(af_b), 32'(sz >= 4));
      if (sz != 0) chk("b_data", 32'(if_b.dout_data), 32'(q[0]));
      if (dr && sz != 0) void'(q.pop_front());
      if (dv && sz < 5) q.push_back(dd);
      tick;
    end
    if_b.din_valid = 0; if_b.dout_ready = 0; #1;
    chk("b_final_level", 32'(lvl_b), 32'(q.size()));

    // Reset mid-operation with handshakes in flight
    if_a.din_valid = 1; if_a.din_data = 8'hEE; if_a.dout_ready = 1;
    if_d.din_valid = 1; if_d.din_data = 8'h44;
    rst = 1; tick;
    rst = 0; if_a.din_valid = 0; if_a.dout_ready = 0; if_d.din_valid = 0; #1;
    chk("a_mrst_level",  32'(lvl_a), 0);
    chk("a_mrst_dvalid", 32'(if_a.dout_valid), 0);
    chk("a_mrst_ready",  32'(if_a.din_ready), 1);
    chk("d_mrst_level",  32'(lvl_d), 1);
    chk("d_mrst_data",   32'(if_d.dout_data), 32'h7E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
